// File: rtl/spi_msg_arbiter.sv
// Round-robin arbiter sharing one downstream consumer between N_CH SPI
// input channels. A granted channel is drained for exactly its message
// length, words are tagged with SOP/EOP/channel, and a fixed gap follows
// each message so the source can drop GOT_FULL_MSG before re-arbitration.
module spi_msg_arbiter #(
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic                 SYS_CLK,
  input  logic                 RST,
  input  logic [N_CH-1:0]      CH_FULL_MSG,
  input  logic [8*N_CH-1:0]    CH_LEN,
  input  logic [16*N_CH-1:0]   CH_Q,
  output logic [N_CH-1:0]      CH_RD_REQ,
  input  logic                 OUT_READY,
  output logic [15:0]          OUT_DATA,
  output logic                 OUT_VALID,
  output logic                 OUT_SOP,
  output logic                 OUT_EOP,
  output logic [CH_W-1:0]      OUT_CH,
  output logic                 BUSY,
  output logic                 LEN_ERR
);

  localparam int unsigned N_U   = N_CH;
  localparam int          GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  state_t            state;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   last;
  logic [7:0]        remaining;
  logic              first;
  logic [GAP_W-1:0]  counter;

  logic              found;
  logic [CH_W-1:0]   pick;
  logic [CH_W-1:0]   idx;
  logic [7:0]        sel_len;
  logic              rd_issue;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_U; k++) begin
      idx = CH_W'((32'(last) + k) % N_U);
      if (!found && CH_FULL_MSG[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign sel_len  = CH_LEN[{pick, 3'b000} +: 8];
  assign rd_issue = (state == READ) && OUT_READY && (remaining != '0);

  // Read strobe steered to the granted channel only.
  always_comb begin
    CH_RD_REQ = '0;
    for (int unsigned i = 0; i < N_U; i++) begin
      CH_RD_REQ[i] = rd_issue && (grant == CH_W'(i));
    end
  end

  // Data is muxed live from the granted FIFO; gating with OUT_VALID keeps
  // the bus at zero outside valid words, including straight after reset.
  assign OUT_DATA = OUT_VALID ? CH_Q[{grant, 4'b0000} +: 16] : '0;
  assign OUT_CH   = grant;

  // Arbitration FSM with registered output pipeline.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= CH_W'(N_CH - 1);
      remaining <= '0;
      first     <= 1'b0;
      counter   <= '0;
      OUT_VALID <= 1'b0;
      OUT_SOP   <= 1'b0;
      OUT_EOP   <= 1'b0;
      BUSY      <= 1'b0;
      LEN_ERR   <= 1'b0;
    end else begin
      OUT_VALID <= rd_issue;
      OUT_SOP   <= rd_issue && first;
      OUT_EOP   <= rd_issue && (remaining == 8'd1);
      LEN_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant     <= pick;
            last      <= pick;
            remaining <= sel_len;
            first     <= 1'b1;
            BUSY      <= 1'b1;
            if (sel_len == '0) begin
              LEN_ERR <= 1'b1;
              counter <= '0;
              state   <= GAP;
            end else begin
              state   <= READ;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            remaining <= remaining - 8'd1;
            first     <= 1'b0;
            if (remaining == 8'd1) begin
              counter <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (counter == GAP_W'(GAP_CYCLES - 1)) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            counter <= counter + GAP_W'(1);
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_msg_arbiter.sv
// Directed bench for spi_msg_arbiter with a simple per-channel FIFO source.
module tb_spi_msg_arbiter;

  localparam int N_CH       = 4;
  localparam int CH_W       = 2;
  localparam int GAP_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  full;
  logic [31:0] len;
  logic [63:0] q_bus;
  logic [3:0]  rd_req;
  logic        ready;
  logic [15:0] data;
  logic        valid, sop, eop;
  logic [1:0]  och;
  logic        busy, len_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_msg_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .SYS_CLK     (clk),
    .RST         (rst),
    .CH_FULL_MSG (full),
    .CH_LEN      (len),
    .CH_Q        (q_bus),
    .CH_RD_REQ   (rd_req),
    .OUT_READY   (ready),
    .OUT_DATA    (data),
    .OUT_VALID   (valid),
    .OUT_SOP     (sop),
    .OUT_EOP     (eop),
    .OUT_CH      (och),
    .BUSY        (busy),
    .LEN_ERR     (len_err)
  );

  function automatic logic [15:0] expd(input int ch, input int s);
    return {4'hA, ch[3:0], s[7:0]};
  endfunction

  // Source FIFOs: each read returns the next sequence word one cycle later.
  logic [15:0] src_q   [4];
  logic [7:0]  src_seq [4];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        src_q[i]   <= '0;
        src_seq[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rd_req[i]) begin
          src_q[i]   <= expd(i, int'(src_seq[i]));
          src_seq[i] <= src_seq[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    q_bus = '0;
    for (int i = 0; i < 4; i++) q_bus[16*i +: 16] = src_q[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},    32'(rd_req),  32'd0);
    chk({tag, "_valid"}, 32'(valid),   32'd0);
    chk({tag, "_sop"},   32'(sop),     32'd0);
    chk({tag, "_eop"},   32'(eop),     32'd0);
    chk({tag, "_busy"},  32'(busy),    32'd0);
    chk({tag, "_lerr"},  32'(len_err), 32'd0);
    chk({tag, "_ch"},    32'(och),     32'd0);
    chk({tag, "_data"},  32'(data),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic pat [9];
  int   es  [4];

  initial begin
    logic prev;
    int   words, reads, msgs, wcnt, w;
    full = '0; len = '0; ready = 1'b0; rst = 1'b1;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    // Channel 0, length 4, ready always high
    @(negedge clk);
    full = 4'b0001; len[7:0] = 8'd4; ready = 1'b1;
    #1 chk("t1_idle_busy", 32'(busy), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) full = '0;
      #1;
      chk("t1_rd",    32'(rd_req), (c <= 4) ? 32'd1 : 32'd0);
      chk("t1_valid", 32'(valid),  32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        chk("t1_data", 32'(data), 32'(expd(0, c - 2)));
        chk("t1_sop",  32'(sop),  32'(c == 2));
        chk("t1_eop",  32'(eop),  32'(c == 5));
        chk("t1_ch",   32'(och),  32'd0);
      end
      chk("t1_busy", 32'(busy), 32'(c <= 7));
    end

    // Length-1 message on channel 2
    full = 4'b0100; len[23:16] = 8'd1;
    @(negedge clk); full = '0;
    #1 chk("t3_rd", 32'(rd_req), 32'h4);
    @(negedge clk);
    #1;
    chk("t3_valid", 32'(valid), 32'd1);
    chk("t3_sop",   32'(sop),   32'd1);
    chk("t3_eop",   32'(eop),   32'd1);
    chk("t3_ch",    32'(och),   32'd2);
    chk("t3_data",  32'(data),  32'(expd(2, 0)));
    chk("t3_rd0",   32'(rd_req), 32'd0);
    @(negedge clk);
    #1 chk("t3_valid_end", 32'(valid), 32'd0);
    @(negedge clk);
    #1 chk("t3_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    #1 chk("t3_busy_idle", 32'(busy), 32'd0);

    // Channel 1, length 6, ready toggling
    full = 4'b0010; len[15:8] = 8'd6; ready = 1'b0;
    prev = 1'b0; words = 0; reads = 0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j == 0) full = '0;
      ready = pat[j];
      #1;
      chk("t4_rd",    32'(rd_req), pat[j] ? 32'h2 : 32'h0);
      if (rd_req != 4'b0) reads++;
      chk("t4_valid", 32'(valid), 32'(prev));
      if (prev) begin
        words++;
        chk("t4_data", 32'(data), 32'(expd(1, words - 1)));
        chk("t4_sop",  32'(sop),  32'(words == 1));
        chk("t4_eop",  32'(eop),  32'(words == 6));
        chk("t4_ch",   32'(och),  32'd1);
      end
      prev = pat[j];
    end
    chk("t4_reads", 32'(reads), 32'd6);
    @(negedge clk); ready = 1'b1;
    #1;
    chk("t4_rd_gap",  32'(rd_req), 32'd0);
    chk("t4_last_v",  32'(valid),  32'd1);
    chk("t4_last_e",  32'(eop),    32'd1);
    chk("t4_last_d",  32'(data),   32'(expd(1, 5)));
    repeat (2) @(negedge clk);
    #1 chk("t4_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    #1 chk("t4_busy_idle", 32'(busy), 32'd0);

    // Channel 3, length 0
    full = 4'b1000; len[31:24] = 8'd0;
    @(negedge clk); full = '0;
    #1;
    chk("t5_lerr",  32'(len_err), 32'd1);
    chk("t5_busy",  32'(busy),    32'd1);
    chk("t5_rd",    32'(rd_req),  32'd0);
    @(negedge clk);
    #1;
    chk("t5_lerr_end", 32'(len_err), 32'd0);
    chk("t5_rd2",      32'(rd_req),  32'd0);
    @(negedge clk);
    #1 chk("t5_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    #1 chk("t5_busy_idle", 32'(busy), 32'd0);

    // All four channels requesting continuously, length 2 each
    full = 4'b1111; len = {4{8'd2}}; ready = 1'b1;
    es[0] = 4; es[1] = 6; es[2] = 1; es[3] = 0;
    msgs = 0; wcnt = 0;
    for (int c = 0; c < 100 && msgs < 8; c++) begin
      @(negedge clk);
      #1;
      chk("t2_onehot", 32'($onehot0(rd_req)), 32'd1);
      if (valid) begin
        chk("t2_ch",   32'(och),  32'(msgs % 4));
        chk("t2_data", 32'(data), 32'(expd(msgs % 4, es[msgs % 4])));
        es[msgs % 4]++;
        wcnt = sop ? 1 : wcnt + 1;
        if (eop) begin
          chk("t2_len", 32'(wcnt), 32'd2);
          msgs++;
        end
      end
    end
    chk("t2_msgs", 32'(msgs), 32'd8);
    full = '0;
    w = 0;
    while (busy && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("t2_idle", 32'(busy), 32'd0);

    // Reset during a 5-word message on channel 2
    full = 4'b0100; len[23:16] = 8'd5;
    @(negedge clk); full = '0;
    #1 chk("t6_rd1", 32'(rd_req), 32'h4);
    @(negedge clk);
    #1;
    chk("t6_rd2",    32'(rd_req), 32'h4);
    chk("t6_valid1", 32'(valid),  32'd1);
    @(negedge clk); rst = 1'b1;
    #1 chk_all_zero("t6_rst");
    @(negedge clk);
    rst = 1'b0; full = 4'b1001; len[7:0] = 8'd1; len[31:24] = 8'd1;
    #1 chk("t6_idle", 32'(busy), 32'd0);
    @(negedge clk); full = '0;
    #1;
    chk("t6_grant0", 32'(rd_req), 32'h1);
    chk("t6_ch",     32'(och),    32'd0);
    @(negedge clk);
    #1;
    chk("t6_valid", 32'(valid), 32'd1);
    chk("t6_data",  32'(data),  32'(expd(0, 0)));
    chk("t6_sope",  32'({sop, eop}), 32'h3);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
